mist_video_out: RTL and testbench

- Parametrised final video output stage for MiST cores; sits between the last pixel-processing stage and the VGA pins.
- Accepts RGB of any depth and HS/VS of either polarity, and auto-detects sync polarity.
- Delay-matches syncs to a configurable colour pipeline, converts colour depth, and generates separate or composite sync in the selected output polarity.

---
 rtl/mist_video_pkg.sv | 32 +++
 rtl/sync_pol_det.sv | 89 ++++++++
 rtl/mist_video_out.sv | 163 ++++++++++++++++
 tb/tb_mist_video_out.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mist_video_pkg.sv
// Shared definitions for the MiST video output stage: sync_mode encodings
// and the colour depth conversion used on every channel.
package mist_video_pkg;

   typedef enum logic [1:0] {
      SYNC_SEP     = 2'b00,
      SYNC_CS_HS   = 2'b01,
      SYNC_CS_BOTH = 2'b10,
      SYNC_SEP_ALT = 2'b11
   } sync_mode_t;

   // Right-aligned in_d-bit value in, right-aligned out_d-bit value out.
   // Output bit k (from the MSB) takes input bit k mod in_d, which gives MSB
   // replication when widening and plain truncation of the LSBs when narrowing.
   function automatic logic [7:0] depth_convert(input logic [7:0] x,
                                                input int         in_d,
                                                input int         out_d);
      logic [7:0] xl;
      logic [7:0] r;
      logic [2:0] idx;
      xl = x << (8 - in_d);
      r  = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < out_d) begin
            idx = 3'(7 - (k % in_d));
            r   = {r[6:0], xl[idx]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_pol_det.sv
// Sync polarity detector: measures high and low times of a sync signal and
// reports active-high when the high time is the shorter of the two.
module sync_pol_det #(
   parameter int CNT_W = 12
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic ce,
   input  logic sync_in,
   output logic pol,
   output logic valid
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync_d_reg;
   logic             started_reg;
   logic             armed_reg;
   logic             have_hi_reg;
   logic             have_lo_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] hi_cnt_reg;
   logic [CNT_W-1:0] lo_cnt_reg;

   logic             edge_det;
   logic             rise;
   logic             fall;
   logic             have_hi_next;
   logic             have_lo_next;
   logic [CNT_W-1:0] hi_cnt_next;
   logic [CNT_W-1:0] lo_cnt_next;

   // The first cycle after reset only primes sync_d_reg, and the first real
   // edge only starts the counter: the interval before it is of unknown length.
   always_comb begin
      edge_det     = started_reg & (sync_in ^ sync_d_reg);
      rise         = edge_det & sync_in;
      fall         = edge_det & ~sync_in;
      hi_cnt_next  = hi_cnt_reg;
      lo_cnt_next  = lo_cnt_reg;
      have_hi_next = have_hi_reg;
      have_lo_next = have_lo_reg;
      if (armed_reg && fall) begin
         hi_cnt_next  = cnt_reg;
         have_hi_next = 1'b1;
      end
      if (armed_reg && rise) begin
         lo_cnt_next  = cnt_reg;
         have_lo_next = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync_d_reg  <= 1'b0;
         started_reg <= 1'b0;
         armed_reg   <= 1'b0;
         have_hi_reg <= 1'b0;
         have_lo_reg <= 1'b0;
         cnt_reg     <= '0;
         hi_cnt_reg  <= '0;
         lo_cnt_reg  <= '0;
         pol         <= 1'b0;
         valid       <= 1'b0;
      end else begin
         sync_d_reg  <= sync_in;
         started_reg <= 1'b1;
         have_hi_reg <= have_hi_next;
         have_lo_reg <= have_lo_next;
         hi_cnt_reg  <= hi_cnt_next;
         lo_cnt_reg  <= lo_cnt_next;
         valid       <= have_hi_next & have_lo_next;
         if (edge_det) begin
            cnt_reg   <= CNT_ONE;
            armed_reg <= 1'b1;
            if (armed_reg && have_hi_next && have_lo_next) begin
               if (hi_cnt_next < lo_cnt_next)
                  pol <= 1'b1;
               else if (hi_cnt_next > lo_cnt_next)
                  pol <= 1'b0;
            end
         end else if (ce && cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/mist_video_out.sv
// Final MiST video output stage: sync polarity detection, delay matching,
// colour depth conversion and separate/composite sync generation.
// Optional build macro MIST_VIDEO_OUT_BLANK_EN forces colour to 0 during sync.
module mist_video_out
   import mist_video_pkg::*;
#(
   parameter int IN_DEPTH     = 6,
   parameter int OUT_DEPTH    = 6,
   parameter int PIPE_STAGES  = 2,
   parameter int H_CNT_W      = 12,
   parameter int V_CNT_W      = 10,
   parameter int SYNC_AND     = 0,
   parameter int OUT_SYNC_NEG = 1
) (
   input  logic                 clk_sys,
   input  logic                 reset_n,
   input  logic [1:0]           sync_mode,
   input  logic [IN_DEPTH-1:0]  R,
   input  logic [IN_DEPTH-1:0]  G,
   input  logic [IN_DEPTH-1:0]  B,
   input  logic                 HSync,
   input  logic                 VSync,
   output logic [OUT_DEPTH-1:0] VGA_R,
   output logic [OUT_DEPTH-1:0] VGA_G,
   output logic [OUT_DEPTH-1:0] VGA_B,
   output logic                 VGA_HS,
   output logic                 VGA_VS,
   output logic                 hs_pol,
   output logic                 vs_pol,
   output logic                 pol_locked
);

   localparam int   PW       = 3 * IN_DEPTH + 2;
   localparam logic SYNC_INV = (OUT_SYNC_NEG != 0);
   localparam logic CS_AND   = (SYNC_AND != 0);

   logic                 hs_act;
   logic                 vs_act;
   logic                 hs_act_d_reg;
   logic                 line_ce;
   logic                 h_valid;
   logic                 v_valid;
   logic [PW-1:0]        pipe_in;
   logic [PW-1:0]        pipe_out;
   logic                 d_hs;
   logic                 d_vs;
   logic                 cs_act;
   logic                 blank;
   logic                 hs_next;
   logic                 vs_next;
   logic [IN_DEPTH-1:0]  dly_rgb  [3];
   logic [OUT_DEPTH-1:0] rgb_next [3];

   // Normalised syncs: 1 = inside the pulse, whatever the input polarity.
   assign hs_act = HSync ^ ~hs_pol;
   assign vs_act = VSync ^ ~vs_pol;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         hs_act_d_reg <= 1'b0;
      else
         hs_act_d_reg <= hs_act;
   end

   assign line_ce = hs_act & ~hs_act_d_reg;

   sync_pol_det #(.CNT_W(H_CNT_W)) u_h_det (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (1'b1),
      .sync_in (HSync),
      .pol     (hs_pol),
      .valid   (h_valid)
   );

   sync_pol_det #(.CNT_W(V_CNT_W)) u_v_det (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (line_ce),
      .sync_in (VSync),
      .pol     (vs_pol),
      .valid   (v_valid)
   );

   assign pol_locked = h_valid & v_valid;

   // Colour and normalised syncs share one delay line so they stay aligned.
   assign pipe_in = {R, G, B, hs_act, vs_act};

   generate
      if (PIPE_STAGES == 0) begin : g_no_dly
         assign pipe_out = pipe_in;
      end else begin : g_dly
         logic [PIPE_STAGES-1:0][PW-1:0] line_reg;
         always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
               line_reg <= '0;
            end else begin
               line_reg[0] <= pipe_in;
               for (int i = 1; i < PIPE_STAGES; i++)
                  line_reg[i] <= line_reg[i-1];
            end
         end
         assign pipe_out = line_reg[PIPE_STAGES-1];
      end
   endgenerate

   assign d_hs = pipe_out[1];
   assign d_vs = pipe_out[0];

`ifdef MIST_VIDEO_OUT_BLANK_EN
   assign blank = d_hs | d_vs;
`else
   assign blank = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         assign dly_rgb[gi]  = pipe_out[2 + (2 - gi) * IN_DEPTH +: IN_DEPTH];
         assign rgb_next[gi] = blank ? '0 :
            OUT_DEPTH'(depth_convert(8'(dly_rgb[gi]), IN_DEPTH, OUT_DEPTH));
      end
   endgenerate

   // sync_mode is deliberately not delayed: a change shows on the next update.
   always_comb begin
      cs_act  = CS_AND ? (d_hs | d_vs) : (d_hs ^ d_vs);
      hs_next = d_hs;
      vs_next = d_vs;
      case (sync_mode_t'(sync_mode))
         SYNC_CS_HS: begin
            hs_next = cs_act;
            vs_next = 1'b0;
         end
         SYNC_CS_BOTH: begin
            hs_next = cs_act;
            vs_next = cs_act;
         end
         default: begin
            hs_next = d_hs;
            vs_next = d_vs;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         VGA_R  <= '0;
         VGA_G  <= '0;
         VGA_B  <= '0;
         VGA_HS <= SYNC_INV;
         VGA_VS <= SYNC_INV;
      end else begin
         VGA_R  <= rgb_next[0];
         VGA_G  <= rgb_next[1];
         VGA_B  <= rgb_next[2];
         VGA_HS <= hs_next ^ SYNC_INV;
         VGA_VS <= vs_next ^ SYNC_INV;
      end
   end

endmodule

// File: tb/tb_mist_video_out.sv
// Scoreboard bench for mist_video_out: three instances with different depth,
// composite-sync and output-polarity settings driven by one video timing.
module tb_mist_video_out;

   localparam int P           = 2;
   localparam int HS_LEN      = 8;
   localparam int LINE_LEN    = 48;
   localparam int VS_LINES    = 2;
   localparam int FRAME_LINES = 12;

   typedef struct {
      logic chk;
      logic hp;
      logic vp;
      int   ir;
      int   ig;
      int   ib;
      int   due;
   } exp_t;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [1:0] sync_mode;
   logic       HSync;
   logic       VSync;
   logic [7:0] vr;
   logic [7:0] vg;
   logic [7:0] vb;

   logic [5:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
   logic       a_hs, a_vs, a_hp, a_vp, a_lk;
   logic       b_hs, b_vs, b_hp, b_vp, b_lk;
   logic       c_hs, c_vs, c_hp, c_vp, c_lk;

   // Hand-computed colour vectors: input byte and expected 6-bit output for
   // A (6->6, low 6 bits), B (4->6, low nibble MSB-replicated), C (8->6, top 6 bits).
   logic [7:0] ctab  [5] = '{8'hFB, 8'hFF, 8'h00, 8'h96, 8'h4D};
   logic [5:0] exp_a [5] = '{6'h3B, 6'h3F, 6'h00, 6'h16, 6'h0D};
   logic [5:0] exp_b [5] = '{6'h2E, 6'h3F, 6'h00, 6'h19, 6'h37};
   logic [5:0] exp_c [5] = '{6'h3E, 6'h3F, 6'h00, 6'h25, 6'h13};

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   mist_video_out #(.IN_DEPTH(6), .OUT_DEPTH(6), .PIPE_STAGES(P), .H_CNT_W(12),
                    .V_CNT_W(10), .SYNC_AND(0), .OUT_SYNC_NEG(1)) dut_a (
      .clk_sys(clk_sys), .reset_n(reset_n), .sync_mode(sync_mode),
      .R(vr[5:0]), .G(vg[5:0]), .B(vb[5:0]), .HSync(HSync), .VSync(VSync),
      .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs),
      .hs_pol(a_hp), .vs_pol(a_vp), .pol_locked(a_lk));

   mist_video_out #(.IN_DEPTH(4), .OUT_DEPTH(6), .PIPE_STAGES(P), .H_CNT_W(12),
                    .V_CNT_W(10), .SYNC_AND(1), .OUT_SYNC_NEG(0)) dut_b (
      .clk_sys(clk_sys), .reset_n(reset_n), .sync_mode(sync_mode),
      .R(vr[3:0]), .G(vg[3:0]), .B(vb[3:0]), .HSync(HSync), .VSync(VSync),
      .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
      .hs_pol(b_hp), .vs_pol(b_vp), .pol_locked(b_lk));

   mist_video_out #(.IN_DEPTH(8), .OUT_DEPTH(6), .PIPE_STAGES(P), .H_CNT_W(12),
                    .V_CNT_W(10), .SYNC_AND(0), .OUT_SYNC_NEG(1)) dut_c (
      .clk_sys(clk_sys), .reset_n(reset_n), .sync_mode(sync_mode),
      .R(vr), .G(vg), .B(vb), .HSync(HSync), .VSync(VSync),
      .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .VGA_HS(c_hs), .VGA_VS(c_vs),
      .hs_pol(c_hp), .vs_pol(c_vp), .pol_locked(c_lk));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic map_sync(input logic h, input logic v, input logic sand, input logic neg,
                           output logic hs, output logic vs);
      logic cs;
      cs = sand ? (h | v) : (h ^ v);
      case (sync_mode)
         2'b01:   begin hs = cs; vs = 1'b0; end
         2'b10:   begin hs = cs; vs = cs;   end
         default: begin hs = h;  vs = v;    end
      endcase
      hs = hs ^ neg;
      vs = vs ^ neg;
   endtask

   task automatic check_entry(input exp_t e);
      logic hs_e, vs_e, blank;
`ifdef MIST_VIDEO_OUT_BLANK_EN
      blank = e.hp | e.vp;
`else
      blank = 1'b0;
`endif
      map_sync(e.hp, e.vp, 1'b0, 1'b1, hs_e, vs_e);
      chk("A.HS", 8'(a_hs), 8'(hs_e));
      chk("A.VS", 8'(a_vs), 8'(vs_e));
      map_sync(e.hp, e.vp, 1'b1, 1'b0, hs_e, vs_e);
      chk("B.HS", 8'(b_hs), 8'(hs_e));
      chk("B.VS", 8'(b_vs), 8'(vs_e));
      map_sync(e.hp, e.vp, 1'b0, 1'b1, hs_e, vs_e);
      chk("C.HS", 8'(c_hs), 8'(hs_e));
      chk("C.VS", 8'(c_vs), 8'(vs_e));
      chk("A.R", 8'(a_r), blank ? 8'h00 : 8'(exp_a[e.ir]));
      chk("A.G", 8'(a_g), blank ? 8'h00 : 8'(exp_a[e.ig]));
      chk("A.B", 8'(a_b), blank ? 8'h00 : 8'(exp_a[e.ib]));
      chk("B.R", 8'(b_r), blank ? 8'h00 : 8'(exp_b[e.ir]));
      chk("B.G", 8'(b_g), blank ? 8'h00 : 8'(exp_b[e.ig]));
      chk("B.B", 8'(b_b), blank ? 8'h00 : 8'(exp_b[e.ib]));
      chk("C.R", 8'(c_r), blank ? 8'h00 : 8'(exp_c[e.ir]));
      chk("C.G", 8'(c_g), blank ? 8'h00 : 8'(exp_c[e.ig]));
      chk("C.B", 8'(c_b), blank ? 8'h00 : 8'(exp_c[e.ib]));
   endtask

   task automatic check_pol(input string tag, input logic pol_e);
      chk({tag, " A.hs_pol"}, 8'(a_hp), 8'(pol_e));
      chk({tag, " A.vs_pol"}, 8'(a_vp), 8'(pol_e));
      chk({tag, " B.hs_pol"}, 8'(b_hp), 8'(pol_e));
      chk({tag, " B.vs_pol"}, 8'(b_vp), 8'(pol_e));
      chk({tag, " C.hs_pol"}, 8'(c_hp), 8'(pol_e));
      chk({tag, " C.vs_pol"}, 8'(c_vp), 8'(pol_e));
      chk({tag, " A.locked"}, 8'(a_lk), 8'h01);
      chk({tag, " B.locked"}, 8'(b_lk), 8'h01);
      chk({tag, " C.locked"}, 8'(c_lk), 8'h01);
   endtask

   // Drives whole frames and pushes one expected entry per pixel clock.
   task automatic run_frames(input int n, input logic act_high, input logic [1:0] mode,
                             input logic chk_en);
      exp_t e;
      for (int f = 0; f < n; f++) begin
         for (int ln = 0; ln < FRAME_LINES; ln++) begin
            for (int px = 0; px < LINE_LEN; px++) begin
               @(negedge clk_sys);
               sync_mode = mode;
               e.hp  = (px < HS_LEN);
               e.vp  = (ln < VS_LINES);
               HSync = act_high ? e.hp : ~e.hp;
               VSync = act_high ? e.vp : ~e.vp;
               e.ir  = (px + ln) % 5;
               e.ig  = (px + 2 * ln + 1) % 5;
               e.ib  = (px + 3) % 5;
               vr    = ctab[e.ir];
               vg    = ctab[e.ig];
               vb    = ctab[e.ib];
               e.chk = chk_en;
               e.due = cyc + P + 1;
               sb.push_back(e);
            end
         end
      end
      $display("frames=%0d act_high=%0d mode=%0d checked=%0d total=%0d bad=%0d",
               n, act_high, mode, chk_en, total, bad);
   endtask

   // Monitor: pops each entry on the cycle its result reaches the VGA registers.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_sys);
         #2;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) begin
               total++;
               bad++;
               $display("FAIL sb_late: got cycle %0d expected cycle %0d", cyc, e.due);
            end else if (e.chk) begin
               check_entry(e);
            end
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      sync_mode = 2'b00;
      HSync     = 1'b1;
      VSync     = 1'b1;
      vr = 8'h00; vg = 8'h00; vb = 8'h00;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk_sys);
         HSync = 1'($urandom_range(0, 1));
         VSync = 1'($urandom_range(0, 1));
         vr = 8'($urandom); vg = 8'($urandom); vb = 8'($urandom);
      end
      @(negedge clk_sys);
      chk("rst A.HS", 8'(a_hs), 8'h01);
      chk("rst A.VS", 8'(a_vs), 8'h01);
      chk("rst B.HS", 8'(b_hs), 8'h00);
      chk("rst B.VS", 8'(b_vs), 8'h00);
      chk("rst C.HS", 8'(c_hs), 8'h01);
      chk("rst A.R", 8'(a_r), 8'h00);
      chk("rst B.G", 8'(b_g), 8'h00);
      chk("rst C.B", 8'(c_b), 8'h00);
      chk("rst A.locked", 8'(a_lk), 8'h00);
      chk("rst A.hs_pol", 8'(a_hp), 8'h00);
      chk("rst B.vs_pol", 8'(b_vp), 8'h00);
      $display("reset checks total=%0d bad=%0d", total, bad);

      HSync = 1'b1;
      VSync = 1'b1;
      vr = 8'h00; vg = 8'h00; vb = 8'h00;
      reset_n = 1'b1;

      run_frames(3, 1'b0, 2'b00, 1'b1);
      check_pol("active-low", 1'b0);
      run_frames(1, 1'b0, 2'b01, 1'b1);
      run_frames(1, 1'b0, 2'b10, 1'b1);
      run_frames(1, 1'b0, 2'b11, 1'b1);

      run_frames(3, 1'b1, 2'b00, 1'b0);
      run_frames(2, 1'b1, 2'b00, 1'b1);
      run_frames(1, 1'b1, 2'b01, 1'b1);
      run_frames(1, 1'b1, 2'b10, 1'b1);
      check_pol("active-high", 1'b1);

      // Stuck syncs: counters saturate, detected polarity must hold.
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk_sys);
         HSync = 1'b0;
         VSync = 1'b0;
      end
      check_pol("stuck", 1'b1);

      repeat (P + 3) @(negedge clk_sys);
      chk("sb drained", 8'(sb.size()), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
